// File: rtl/instr_fetch_if.sv
// Instruction-memory read channel between the fetch stage (master) and memory (slave).
`timescale 1ns/1ps
interface instr_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_fetch_reg.sv
// Fetch stage: owns PC and IR, runs the instruction-memory read handshake with a
// bounded wait, and exposes the decoder's field slices of the held instruction.
`timescale 1ns/1ps
module instr_fetch_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_start,
  input  logic               pc_load,
  input  logic [31:0]        pc_next,
  instr_fetch_if.master      mem,
  output logic [31:0]        pc,
  output logic [31:0]        ir,
  output logic               ir_valid,
  output logic               fetch_busy,
  output logic               fetch_err,
  output logic [5:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic [13:0]        imm14,
  output logic [23:0]        imm24,
  output logic [1:0]         itype
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] STEP     = 32'(PC_STEP);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        irv_q, irv_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      irv_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // PC is only writable outside REQ/WAIT so an in-flight address never moves.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    irv_d   = irv_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pc_load)     pc_d    = pc_next;
        if (fetch_start) state_d = S_REQ;
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + STEP;
          irv_d   = 1'b1;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (pc_load) pc_d = pc_next;
        if (fetch_start) begin
          irv_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.mem_req  = (state_q == S_REQ) || (state_q == S_WAIT);
  assign mem.mem_addr = pc_q;
  assign fetch_busy   = mem.mem_req;

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = irv_q;
  assign fetch_err = err_q;

  assign opcode = ir_q[31:26];
  assign rd     = ir_q[25:22];
  assign rs1    = ir_q[21:18];
  assign rs2    = ir_q[17:14];
  assign imm14  = ir_q[17:4];
  assign imm24  = ir_q[25:2];
  assign itype  = ir_q[1:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed bench for instr_fetch_reg: handshake latency, slicing, pc_load, timeout,
// stray ack, async reset and PC wrap, all against hand-computed values.
`timescale 1ns/1ps
module tb_instr_fetch_reg;

  logic        clk;
  logic        rst_n;
  logic        fetch_start;
  logic        pc_load;
  logic [31:0] pc_next;
  logic [31:0] pc, ir;
  logic        ir_valid, fetch_busy, fetch_err;
  logic [5:0]  opcode;
  logic [3:0]  rd, rs1, rs2;
  logic [13:0] imm14;
  logic [23:0] imm24;
  logic [1:0]  itype;

  int n_chk  = 0;
  int n_pass = 0;

  instr_fetch_if bus ();

  instr_fetch_reg #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4),
    .TIMEOUT  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_start (fetch_start),
    .pc_load     (pc_load),
    .pc_next     (pc_next),
    .mem         (bus.master),
    .pc          (pc),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .fetch_busy  (fetch_busy),
    .fetch_err   (fetch_err),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .imm14       (imm14),
    .imm24       (imm24),
    .itype       (itype)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full fetch from HOLD/IDLE with an ack on the first WAIT cycle.
  task automatic do_fetch(input logic [31:0] word);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = word;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_start = 1'b0; pc_load = 1'b0; pc_next = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    chk("rst_pc",   pc, 32'h0);
    chk("rst_ir",   ir, 32'h0);
    chk("rst_irv",  32'(ir_valid), 32'h0);
    chk("rst_req",  32'(bus.mem_req), 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'h0);
    chk("rst_err",  32'(fetch_err), 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic fetch with cycle-by-cycle latency.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("req_hi",   32'(bus.mem_req), 32'h1);
    chk("req_addr", bus.mem_addr, 32'h0);
    chk("req_busy", 32'(fetch_busy), 32'h1);
    tick();
    chk("wait_req", 32'(bus.mem_req), 32'h1);
    chk("wait_irv", 32'(ir_valid), 32'h0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    chk("f1_ir",   ir, 32'h1234_5678);
    chk("f1_pc",   pc, 32'h4);
    chk("f1_irv",  32'(ir_valid), 32'h1);
    chk("f1_req",  32'(bus.mem_req), 32'h0);
    chk("f1_busy", 32'(fetch_busy), 32'h0);

    // Field slicing.
    do_fetch(32'hFC00_3FF1);
    chk("fs_pc",     pc, 32'h8);
    chk("fs_opcode", 32'(opcode), 32'h3F);
    chk("fs_rd",     32'(rd), 32'h0);
    chk("fs_rs1",    32'(rs1), 32'h0);
    chk("fs_rs2",    32'(rs2), 32'h0);
    chk("fs_imm14",  32'(imm14), 32'h03FF);
    chk("fs_imm24",  32'(imm24), 32'h000FFC);
    chk("fs_itype",  32'(itype), 32'h1);
    do_fetch(32'h5A3C_9E6B);
    chk("fs2_opcode", 32'(opcode), 32'h16);
    chk("fs2_rd",     32'(rd), 32'h8);
    chk("fs2_rs1",    32'(rs1), 32'hF);
    chk("fs2_rs2",    32'(rs2), 32'h2);
    chk("fs2_itype",  32'(itype), 32'h3);

    // Branch load together with fetch_start in HOLD.
    pc_load = 1'b1; pc_next = 32'h0000_0100; fetch_start = 1'b1;
    tick();
    pc_load = 1'b0; pc_next = '0; fetch_start = 1'b0;
    chk("br_addr", bus.mem_addr, 32'h100);
    chk("br_ir",   ir, 32'h5A3C_9E6B);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    chk("br_pc", pc, 32'h104);
    chk("br_ir2", ir, 32'h0BAD_F00D);

    // Timeout with pc_load attempted during WAIT.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    pc_load = 1'b1; pc_next = 32'hDEAD_BEE0;
    tick(); tick(); tick();
    chk("to_busy3", 32'(fetch_busy), 32'h1);
    chk("to_err3",  32'(fetch_err), 32'h0);
    tick();
    pc_load = 1'b0; pc_next = '0;
    chk("to_err",  32'(fetch_err), 32'h1);
    chk("to_busy", 32'(fetch_busy), 32'h0);
    chk("to_pc",   pc, 32'h104);
    chk("to_ir",   ir, 32'h0BAD_F00D);
    chk("to_irv",  32'(ir_valid), 32'h0);

    // Stray ack in IDLE.
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
    tick(); tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    chk("sa_ir",  ir, 32'h0BAD_F00D);
    chk("sa_pc",  pc, 32'h104);
    chk("sa_irv", 32'(ir_valid), 32'h0);
    chk("sa_req", 32'(bus.mem_req), 32'h0);

    // Retry after timeout.
    do_fetch(32'h2222_3333);
    chk("rt_ir",  ir, 32'h2222_3333);
    chk("rt_pc",  pc, 32'h108);
    chk("rt_irv", 32'(ir_valid), 32'h1);
    chk("rt_err", 32'(fetch_err), 32'h1);

    // PC wrap.
    pc_load = 1'b1; pc_next = 32'hFFFF_FFFC;
    tick();
    pc_load = 1'b0; pc_next = '0;
    chk("wr_load", pc, 32'hFFFF_FFFC);
    chk("wr_ir",   ir, 32'h2222_3333);
    do_fetch(32'hCAFE_0001);
    chk("wr_pc", pc, 32'h0);
    chk("wr_ir2", ir, 32'hCAFE_0001);

    // Asynchronous reset in WAIT, ack pending.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_7777;
    chk("ar_pre", 32'(bus.mem_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req",  32'(bus.mem_req), 32'h0);
    chk("ar_pc",   pc, 32'h0);
    chk("ar_ir",   ir, 32'h0);
    chk("ar_err",  32'(fetch_err), 32'h0);
    chk("ar_busy", 32'(fetch_busy), 32'h0);
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    rst_n = 1'b1;
    tick();
    chk("ar_ir2",  ir, 32'h0);
    chk("ar_irv",  32'(ir_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
